// File: rtl/memory_unit_pkg.sv
// Shared encodings for the memory stage: load/store funct3 codes, AMO funct7[6:2]
// codes and the bubble instruction word.
package memory_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  // Store access size lives in funct3[1:0]
  typedef enum logic [1:0] {
    ST_B = 2'b00,
    ST_H = 2'b01,
    ST_W = 2'b10
  } store_size_e;

  localparam logic [4:0] AMO_LR = 5'b00010;
  localparam logic [4:0] AMO_SC = 5'b00011;

endpackage

// File: rtl/memory_unit_load_align.sv
// Load alignment: selects the byte/halfword lane of an already-fetched word and
// sign- or zero-extends it according to funct3.
module mem_load_align
  import memory_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/memory_unit.sv
// RV32 memory stage: data-memory/CSR write strobes, load alignment, LR/SC
// reservation and the registered MW writeback triple. Define RV32A_EN for atomics.
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        M_stall_i,
  input  logic [31:0] EM_PC_i,
  input  logic [31:0] EM_instr_i,
  input  logic        EM_nop_i,
  input  logic        EM_isLoad_i,
  input  logic        EM_isStore_i,
  input  logic        EM_isCSR_i,
  input  logic        EM_isAMO_i,
  input  logic        EM_wbEnable_i,
  input  logic [5:0]  EM_rdId_i,
  input  logic [5:0]  EM_rs1Id_i,
  input  logic [11:0] EM_csrId_i,
  input  logic [2:0]  EM_funct3_i,
  input  logic [6:0]  EM_funct7_i,
  input  logic [31:0] EM_rs2_i,
  input  logic [31:0] EM_Eresult_i,
  input  logic [31:0] EM_addr_i,
  input  logic [31:0] EM_Mdata_i,
  input  logic [31:0] EM_CSRdata_i,
  output logic [31:0] DMemWAddr_o,
  output logic [31:0] DMemWData_o,
  output logic [3:0]  DMemWMask_o,
  output logic        csrWEnable_o,
  output logic [11:0] csrWAddr_o,
  output logic [31:0] csrWData_o,
  output logic [31:0] MW_PC_o,
  output logic [31:0] MW_instr_o,
  output logic        MW_nop_o,
  output logic        MW_wbEnable_o,
  output logic [5:0]  MW_rdId_o,
  output logic [31:0] MW_wbData_o
);

  logic        w_active;
  logic [29:0] w_word;
  logic [31:0] w_load_data;
  logic        w_amo;
  logic        w_lr;
  logic        w_sc;
  logic        w_sc_ok;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic [31:0] w_wb_data;

  assign w_active = !EM_nop_i && !M_stall_i && !reset_i;
  assign w_word   = EM_addr_i[31:2];

  mem_load_align u_load_align (
    .i_funct3  (EM_funct3_i),
    .i_addr_lo (EM_addr_i[1:0]),
    .i_word    (EM_Mdata_i),
    .o_data    (w_load_data)
  );

`ifdef RV32A_EN
  logic        r_res_valid;
  logic [29:0] r_res_addr;
  logic        w_unused;

  assign w_amo    = EM_isAMO_i;
  assign w_lr     = w_amo && (EM_funct7_i[6:2] == AMO_LR);
  assign w_sc     = w_amo && (EM_funct7_i[6:2] == AMO_SC);
  assign w_sc_ok  = r_res_valid && (r_res_addr == w_word);
  assign w_unused = ^{EM_funct7_i[1:0], EM_rs1Id_i[5]};

  // Any committed write to the reserved word, or an SC, drops the reservation.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_res_valid <= 1'b0;
    end else if (w_active) begin
      if (w_lr) begin
        r_res_valid <= 1'b1;
        r_res_addr  <= w_word;
      end else if (w_sc || ((w_mask != 4'b0000) && (w_word == r_res_addr))) begin
        r_res_valid <= 1'b0;
      end
    end
  end
  // NOTE: r_res_addr has no reset; it is only observed while r_res_valid is set.
`else
  logic w_unused;

  assign w_amo    = 1'b0;
  assign w_lr     = 1'b0;
  assign w_sc     = 1'b0;
  assign w_sc_ok  = 1'b0;
  assign w_unused = ^{EM_isAMO_i, EM_funct7_i, EM_rs1Id_i[5]};
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_mask  = 4'b0000;
    w_wdata = EM_rs2_i;
    if (w_active) begin
      if (w_amo) begin
        if (w_sc) begin
          if (w_sc_ok) w_mask = 4'b1111;
        end else if (!w_lr) begin
          w_mask  = 4'b1111;
          w_wdata = EM_Eresult_i;
        end
      end else if (EM_isStore_i) begin
        case (EM_funct3_i[1:0])
          ST_B: begin
            w_mask  = 4'b0001 << EM_addr_i[1:0];
            w_wdata = {4{EM_rs2_i[7:0]}};
          end
          ST_H: begin
            w_mask  = EM_addr_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{EM_rs2_i[15:0]}};
          end
          default: w_mask = 4'b1111;
        endcase
      end
    end
  end

  assign DMemWAddr_o = {EM_addr_i[31:2], 2'b00};
  assign DMemWData_o = w_wdata;
  assign DMemWMask_o = w_mask;

  assign csrWAddr_o   = EM_csrId_i;
  assign csrWData_o   = EM_Eresult_i;
  assign csrWEnable_o = w_active && EM_isCSR_i &&
                        ((EM_funct3_i[1:0] == 2'b01) ||
                         (EM_funct3_i[1] && (EM_rs1Id_i[4:0] != 5'd0)));

  always_comb begin
    w_wb_data = EM_Eresult_i;
    if (EM_isLoad_i)      w_wb_data = w_load_data;
    else if (w_amo)       w_wb_data = w_sc ? {31'd0, !w_sc_ok} : EM_Mdata_i;
    else if (EM_isCSR_i)  w_wb_data = EM_CSRdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      MW_PC_o       <= 32'd0;
      MW_instr_o    <= NOP;
      MW_nop_o      <= 1'b1;
      MW_wbEnable_o <= 1'b0;
      MW_rdId_o     <= 6'd0;
      MW_wbData_o   <= 32'd0;
    end else if (!M_stall_i) begin
      MW_PC_o       <= EM_PC_i;
      MW_instr_o    <= EM_instr_i;
      MW_nop_o      <= EM_nop_i;
      MW_wbEnable_o <= !EM_nop_i && EM_wbEnable_i && (EM_rdId_i != 6'd0);
      MW_rdId_o     <= EM_rdId_i;
      MW_wbData_o   <= w_wb_data;
    end
  end

endmodule

// File: doc/memory_unit.md
# memory_unit

Memory stage of the five-stage RV32 pipeline, between the execute unit (EM_* register bank) and writeback. Commits stores, AMO and SC writes to data memory, aligns and sign-extends load data that execute already fetched, commits CSR writes, tracks the LR/SC reservation, and registers the writeback triple (MW_wbEnable/MW_rdId/MW_wbData) that writeback consumes and execute forwards from.

## Interface
Parameters:
- NOP, 32'h0000_0033, instruction word loaded into MW_instr_o on reset

Ports:
- clk_i  in  1  clock; all state on posedge
- reset_i  in  1  reset, synchronous, active-high
- M_stall_i  in  1  hold MW registers; suppress all writes this cycle
- EM_PC_i, EM_instr_i  in  32 each  from execute
- EM_nop_i, EM_isLoad_i, EM_isStore_i, EM_isCSR_i, EM_isAMO_i, EM_wbEnable_i  in  1 each
- EM_rdId_i, EM_rs1Id_i  in  6 each  bit 5 selects FP file
- EM_csrId_i  in  12
- EM_funct3_i  in  3;  EM_funct7_i  in  7
- EM_rs2_i, EM_Eresult_i, EM_addr_i, EM_Mdata_i, EM_CSRdata_i  in  32 each
- DMemWAddr_o  out  32  word address {EM_addr_i[31:2],2'b00}
- DMemWData_o  out  32  byte-lane-positioned store data
- DMemWMask_o  out  4  byte enables; 4'b0000 = no write
- csrWEnable_o  out  1;  csrWAddr_o  out  12;  csrWData_o  out  32
- MW_PC_o, MW_instr_o  out  32 each;  MW_nop_o  out  1
- MW_wbEnable_o  out  1;  MW_rdId_o  out  6;  MW_wbData_o  out  32

## Operation
- Active = !EM_nop_i && !M_stall_i && !reset_i. All write strobes (DMemWMask_o, csrWEnable_o) are zero unless Active; combinational from EM inputs.
- Loads (funct3): 000 LB, 001 LH, 010 LW/FLW, 100 LBU, 101 LHU. Byte lane = EM_addr_i[1:0]; halfword lane = EM_addr_i[1] (bit 0 ignored); word ignores [1:0]. B/H sign-extended unless funct3[2].
- Stores: SB mask 4'b0001<<addr[1:0], data byte replicated x4; SH mask 4'b0011 or 4'b1100 by addr[1], halfword replicated x2; SW mask 4'b1111, data EM_rs2_i.
- AMO (EM_isAMO_i), funct7[6:2]:
  - 00010 LR: no write; rd = EM_Mdata_i; reservation valid, resAddr = addr[31:2].
  - 00011 SC: success iff reservation valid and resAddr == addr[31:2]; success writes EM_rs2_i mask 4'b1111, rd = 0; failure no write, rd = 1. Reservation cleared either way.
  - other: write EM_Eresult_i mask 4'b1111; rd = EM_Mdata_i (old value).
- Any Active plain store or AMO write to resAddr clears reservation.
- CSR: csrWAddr_o = EM_csrId_i, csrWData_o = EM_Eresult_i; csrWEnable_o for funct3[1:0]==01 always, for 10/11 only if EM_rs1Id_i[4:0] != 0. rd = EM_CSRdata_i.
- Writeback mux priority: load > AMO/LR/SC > CSR > EM_Eresult_i.

## Timing
- MW_* registered, one cycle after EM_* present; writes same cycle as EM_* (0 latency).
- M_stall_i high: MW_* and reservation hold; no writes. A stalled instruction writes exactly once, in the cycle stall drops.
- reset_i: MW_wbEnable_o 0, MW_nop_o 1, MW_instr_o NOP, MW_PC_o/MW_rdId_o/MW_wbData_o 0, reservation invalid; reset beats stall; no writes in reset cycle.
- EM_nop_i (not stalled): MW_nop_o 1, MW_wbEnable_o 0, no writes, reservation unchanged.
- MW_wbEnable_o = EM_wbEnable_i && EM_rdId_i != 0.

## Configuration
- RV32A_EN defined: LR/SC/AMO paths and reservation register present.
- Undefined: EM_isAMO_i ignored (treated as ALU result: no write, rd = EM_Eresult_i); no reservation state.

## Structure
- Shared package: load/store funct3 codes, AMO funct7[6:2] codes (LR, SC), NOP constant.
- One sub-module: mem_load_align (funct3, addr[1:0], word -> aligned 32-bit value), purely combinational.

## Test plan
- LB addr ..02, Mdata 0x80FF_1234 -> wbData 0xFFFF_FFFF; LBU -> 0x0000_00FF; LH addr ..02 -> 0xFFFF_80FF.
- SB addr ..03, rs2 0x0000_00AB -> mask 4'b1000, wdata 0xABAB_ABAB; SH addr ..02 -> mask 4'b1100.
- LR 0x100 then SC 0x100 rs2 5 -> write 5, rd 0; second SC 0x100 -> no write, rd 1.
- LR 0x100, SW 0x100, SC 0x100 -> SC fails, rd 1; LR 0x100, SC 0x104 -> fails.
- AMO Eresult 7, Mdata 3 held by M_stall_i 3 cycles -> single write of 7 when stall drops, wbData 3.
- CSRRS rs1Id 0, CSRdata 0x55 -> csrWEnable_o 0, wbData 0x55; reset mid-stall -> MW_nop_o 1, MW_wbEnable_o 0.
